// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Two-requester register-file write-port arbiter. Requester 0
//                is the ALU writeback, requester 1 the memory load. Grants are
//                combinational; the winning write is registered one cycle later
//                and counted. A one-entry forwarding lookup matches rd_addr
//                against the write currently being presented.
//                Writes to address 0 are accepted but dropped.
//                Build option REG_WRITE_ARBITER_RR_EN: round-robin arbitration
//                on contention; when undefined, requester 1 always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       wr_count
);

    logic              w_pick0;     // on contention, requester 0 wins
    logic              w_ready0;
    logic              w_ready1;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_write;     // a transfer that actually writes (addr != 0)

    logic              r_regwrite;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [15:0]       r_count;

`ifdef REG_WRITE_ARBITER_RR_EN
    localparam logic [0:0] c_LAST0 = 1'b0;
    localparam logic [0:0] c_LAST1 = 1'b1;

    logic [0:0] r_ptr;
    logic [0:0] w_ptr_next;

    // Round-robin pointer register; reset makes requester 0 the first winner.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_ptr <= c_LAST1;
        else       r_ptr <= w_ptr_next;
    end

    // Pointer moves only on a real transfer, to the side that just won.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_ready0)      w_ptr_next = c_LAST0;
        else if (w_ready1) w_ptr_next = c_LAST1;
    end

    assign w_pick0 = (r_ptr == c_LAST1);
`else
    // Fixed priority: the memory load always wins a tie.
    assign w_pick0 = 1'b0;
`endif

    // Grant logic: a lone requester wins immediately; reset blocks all grants.
    always_comb begin
        w_ready0   = ~Reset & req0_valid & (~req1_valid | w_pick0);
        w_ready1   = ~Reset & req1_valid & (~req0_valid | ~w_pick0);
        w_sel_addr = w_ready0 ? req0_addr : req1_addr;
        w_sel_data = w_ready0 ? req0_data : req1_data;
        w_write    = (w_ready0 | w_ready1) & (w_sel_addr != '0);
    end

    // Write-port register and commit counter; address 0 transfers leave the
    // presented address/data untouched and do not count.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_regwrite <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_count    <= '0;
        end else begin
            r_regwrite <= w_write;
            if (w_write) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_count   <= r_count + 16'd1;
            end
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign RegWrite   = r_regwrite;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_count   = r_count;
    assign fwd_hit    = r_regwrite & (rd_addr == r_wr_addr);
    assign fwd_data   = fwd_hit ? r_wr_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Self-checking bench for reg_write_arbiter. Table of directed
//                vectors plus hand sequences for forwarding and mid-stream
//                reset. Honours REG_WRITE_ARBITER_RR_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
`ifdef REG_WRITE_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              v0, v1;
    logic [ADDR_W-1:0] a0, a1, rd;
    logic [DATA_W-1:0] d0, d1;
    logic              r0, r1, rw, hit;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd, fd;
    logic [15:0]       cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(clk), .Reset(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1),
        .req0_ready(r0), .req1_ready(r1),
        .RegWrite(rw), .wr_addr(wa), .wr_data(wd),
        .rd_addr(rd), .fwd_hit(hit), .fwd_data(fd),
        .wr_count(cnt)
    );

    typedef struct {
        logic        rst, v0, v1;
        logic [3:0]  a0, a1, rd;
        logic [15:0] d0, d1;
        logic        r0, r1, rw, hit;
        logic [3:0]  wa;
        logic [15:0] wd, cnt, fd;
    } vec_t;

    function automatic vec_t mk(logic rs, logic iv0, logic [3:0] ia0, logic [15:0] id0,
                                logic iv1, logic [3:0] ia1, logic [15:0] id1, logic [3:0] ird,
                                logic er0, logic er1, logic erw, logic [3:0] ewa,
                                logic [15:0] ewd, logic [15:0] ecnt, logic ehit, logic [15:0] efd);
        vec_t t;
        t.rst = rs; t.v0 = iv0; t.a0 = ia0; t.d0 = id0;
        t.v1 = iv1; t.a1 = ia1; t.d1 = id1; t.rd = ird;
        t.r0 = er0; t.r1 = er1; t.rw = erw; t.wa = ewa;
        t.wd = ewd; t.cnt = ecnt; t.hit = ehit; t.fd = efd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector just after an edge, check grants mid-cycle, then check
    // the registered result just after the following edge.
    task automatic step(input vec_t t, input int idx);
        rst = t.rst; v0 = t.v0; a0 = t.a0; d0 = t.d0;
        v1 = t.v1; a1 = t.a1; d1 = t.d1; rd = t.rd;
        @(negedge clk);
        chk($sformatf("v%0d req0_ready", idx), {31'd0, r0}, {31'd0, t.r0});
        chk($sformatf("v%0d req1_ready", idx), {31'd0, r1}, {31'd0, t.r1});
        @(posedge clk); #1;
        chk($sformatf("v%0d RegWrite", idx), {31'd0, rw}, {31'd0, t.rw});
        chk($sformatf("v%0d wr_addr", idx), {28'd0, wa}, {28'd0, t.wa});
        chk($sformatf("v%0d wr_data", idx), {16'd0, wd}, {16'd0, t.wd});
        chk($sformatf("v%0d wr_count", idx), {16'd0, cnt}, {16'd0, t.cnt});
        chk($sformatf("v%0d fwd_hit", idx), {31'd0, hit}, {31'd0, t.hit});
        chk($sformatf("v%0d fwd_data", idx), {16'd0, fd}, {16'd0, t.fd});
    endtask

    vec_t tbl[10];

    initial begin
        // Contention vectors depend on the arbitration policy.
        tbl[0] = mk(0, 1, 4'd3, 16'h0014, 0, 4'd0, 16'h0000, 4'd0, 1, 0, 1, 4'd3, 16'h0014, 16'd1, 0, 16'h0000);
        tbl[1] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 4'd3, 0, 0, 0, 4'd3, 16'h0014, 16'd1, 0, 16'h0000);
        tbl[2] = mk(1, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd0, 0, 0, 0, 4'd0, 16'h0000, 16'd0, 0, 16'h0000);
        if (RR) begin
            tbl[3] = mk(0, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd2, 1, 0, 1, 4'd1, 16'h00AA, 16'd1, 0, 16'h0000);
            tbl[4] = mk(0, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd2, 0, 1, 1, 4'd2, 16'h00BB, 16'd2, 1, 16'h00BB);
            tbl[5] = mk(0, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd2, 1, 0, 1, 4'd1, 16'h00AA, 16'd3, 0, 16'h0000);
            tbl[6] = mk(0, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd2, 0, 1, 1, 4'd2, 16'h00BB, 16'd4, 1, 16'h00BB);
        end else begin
            for (int k = 3; k <= 6; k++)
                tbl[k] = mk(0, 1, 4'd1, 16'h00AA, 1, 4'd2, 16'h00BB, 4'd2, 0, 1, 1, 4'd2, 16'h00BB, 16'(k - 2), 1, 16'h00BB);
        end
        tbl[7] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd0, 16'hFFFF, 4'd2, 0, 1, 0, 4'd2, 16'h00BB, 16'd4, 0, 16'h0000);
        tbl[8] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd7, 16'h0777, 4'd7, 0, 1, 1, 4'd7, 16'h0777, 16'd5, 1, 16'h0777);
        if (RR)
            tbl[9] = mk(0, 1, 4'd9, 16'h0909, 1, 4'd10, 16'h0A0A, 4'd0, 1, 0, 1, 4'd9, 16'h0909, 16'd6, 0, 16'h0000);
        else
            tbl[9] = mk(0, 1, 4'd9, 16'h0909, 1, 4'd10, 16'h0A0A, 4'd0, 0, 1, 1, 4'd10, 16'h0A0A, 16'd6, 0, 16'h0000);

        rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; rd = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset RegWrite", {31'd0, rw}, 32'd0);
        chk("reset wr_addr", {28'd0, wa}, 32'd0);
        chk("reset wr_data", {16'd0, wd}, 32'd0);
        chk("reset wr_count", {16'd0, cnt}, 32'd0);
        chk("reset fwd_hit", {31'd0, hit}, 32'd0);

        for (int i = 0; i < 10; i++) step(tbl[i], i);

        // Forwarding: hit on the written address, miss once rd_addr moves.
        step(mk(0, 1, 4'd5, 16'h1234, 0, 4'd0, 16'h0000, 4'd5, 1, 0, 1, 4'd5, 16'h1234, 16'd7, 1, 16'h1234), 10);
        rd = 4'd6; #1;
        chk("fwd miss hit", {31'd0, hit}, 32'd0);
        chk("fwd miss data", {16'd0, fd}, 32'd0);

        // Two more writes, leaving a committed write on the port, then reset.
        step(mk(0, 0, 4'd0, 16'h0000, 1, 4'd6, 16'h6666, 4'd0, 0, 1, 1, 4'd6, 16'h6666, 16'd8, 0, 16'h0000), 11);
        step(mk(0, 1, 4'd8, 16'h8888, 0, 4'd0, 16'h0000, 4'd8, 1, 0, 1, 4'd8, 16'h8888, 16'd9, 1, 16'h8888), 12);

        // Mid-cycle asynchronous reset with both requesters pending.
        v0 = 1; a0 = 4'd1; d0 = 16'h00AA; v1 = 1; a1 = 4'd2; d1 = 16'h00BB; rd = 4'd0;
        #1 rst = 1'b1; #1;
        chk("async RegWrite", {31'd0, rw}, 32'd0);
        chk("async wr_count", {16'd0, cnt}, 32'd0);
        chk("async wr_addr", {28'd0, wa}, 32'd0);
        chk("async req0_ready", {31'd0, r0}, 32'd0);
        chk("async req1_ready", {31'd0, r1}, 32'd0);
        @(posedge clk); #1;
        chk("held RegWrite", {31'd0, rw}, 32'd0);
        chk("held wr_count", {16'd0, cnt}, 32'd0);
        rst = 1'b0; #1;
        chk("post-reset req0_ready", {31'd0, r0}, {31'd0, RR});
        chk("post-reset req1_ready", {31'd0, r1}, {31'd0, ~RR});
        @(posedge clk); #1;
        chk("post-reset RegWrite", {31'd0, rw}, 32'd1);
        chk("post-reset wr_addr", {28'd0, wa}, RR ? 32'd1 : 32'd2);
        chk("post-reset wr_count", {16'd0, cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Grants must never overlap.
    always @(negedge clk) begin
        if (r0 === 1'b1 && r1 === 1'b1) begin
            errors++;
            $display("FAIL grant overlap: req0_ready=%b req1_ready=%b required not both", r0, r1);
        end
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation time %0t exceeded bound", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
